regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
// Parametrised multi-read-port register file with write-to-read bypass and per-register
// busy scoreboard. Sits in decode of the pipelined RISC-V core.
// Reads feed operand fetch; the single write port is driven by writeback.
// Issue marks a destination pending so decode can detect RAW/WAW hazards.
// PARAMETERS
// DATA_W    32  register width in bits
// ADDR_W    5   address width; depth = 2**ADDR_W entries
// NUM_RD    2   number of independent asynchronous read ports (>=1)
// BYPASS    1   1: same-cycle write data forwarded to matching read ports; 0: no forwarding
// ZERO_REG  1   1: entry 0 hard-wired to zero, never busy; 0: entry 0 is ordinary
// PORTS
// clk       in   1               rising-edge clock
// rst       in   1               synchronous active-high reset
// rd_addr   in   NUM_RD*ADDR_W   read addresses, port i at [i*ADDR_W +: ADDR_W]
// rd_data   out  NUM_RD*DATA_W   read data, port i at [i*DATA_W +: DATA_W]
// rd_busy   out  NUM_RD          port i operand still pending (hazard)
// we        in   1               writeback enable
// wa        in   ADDR_W          writeback address
// wd        in   DATA_W          writeback data
// iss_en    in   1               request to mark iss_addr pending
// iss_addr  in   ADDR_W          destination being issued
// iss_ok    out  1               issue is accepted this cycle
// busy_cnt  out  ADDR_W+1        number of entries currently pending
// BEHAVIOUR
// - Clock is clk. Reset is rst: synchronous, active-high, sampled on the rising edge of clk.
// - rst has priority over all other inputs.
// - On reset, all entries are cleared to 0, all busy bits are cleared to 0, and busy_cnt is 0.
// - One clock after reset, every rd_data reads 0, rd_busy is all 0, and iss_ok is 1.
// - Reads are combinational with zero latency:
//   - rd_data[i] = mem[rd_addr[i]];
//   - rd_busy[i] = busy[rd_addr[i]].
// - Write (when not in reset): if we=1 and the write is legal, mem[wa] <= wd and busy[wa] <= 0.
//   - A write is legal unless ZERO_REG=1 and wa=0.
//   - A write to a non-busy entry is permitted and leaves busy unchanged.
// - Bypass (BYPASS=1): if we=1, the write is legal and wa==rd_addr[i], then
//   rd_data[i]=wd and rd_busy[i]=0 in the same cycle. All matching ports bypass at once.
// - With BYPASS=0 a read of wa returns the old value until the next cycle.
// - With ZERO_REG=1: rd_addr 0 always gives rd_data 0 and rd_busy 0.
// - iss_ok (combinational) = !busy[iss_addr] || (we && wa==iss_addr && the write is legal).
//   Re-issue to a pending register is allowed only when its writeback lands in the same cycle.
// - With ZERO_REG=1 and iss_addr=0: iss_ok=1, but no busy bit is ever set.
// - Accepted issue is iss_en && iss_ok: busy[iss_addr] <= 1 at the next edge.
//   iss_en with iss_ok=0 is ignored and changes no state.
// - Simultaneous write and accepted issue to the same address: the data is written, set wins,
//   and busy stays 1.
// - busy_cnt is registered and updated at the edge with the net change: +1 per 0->1 busy
//   transition, -1 per 1->0 transition.
//   - Write clear and set on the same address: net 0.
//   - Write clear and set on different addresses: net 0.
//   - It never wraps: its range is 0..2**ADDR_W.
// - Reset asserted mid-operation discards all pending state at that edge; there are no partial
//   updates.
// TESTING
// - Reset, then read all 32 entries on both ports -> rd_data=0, rd_busy=0, busy_cnt=0.
// - we=1, wa=5, wd=32'hDEADBEEF, rd_addr0=5, BYPASS=1 -> rd_data0=DEADBEEF in the same cycle.
//   With BYPASS=0 it reads 0 that cycle and DEADBEEF the next.
// - we=1, wa=0, wd=32'h1234; issue iss_addr=0 (ZERO_REG=1) -> rd_data of x0 stays 0,
//   busy_cnt stays 0, iss_ok=1.
// - Issue x7 -> rd_busy=1 for reads of x7, busy_cnt=1, and re-issue of x7 gives iss_ok=0.
//   Then write x7 while re-issuing x7 -> data updated, busy stays 1, busy_cnt=1.
// - Issue x3, then x4, then write x3 while issuing x9 -> busy_cnt goes 1, 2, 2; busy = {x4, x9}.
// - Issue x10, x11, then assert rst with we=1, wa=10 -> busy_cnt=0, mem[10]=0, every iss_ok=1.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with same-cycle write bypass and a per-entry busy scoreboard.
// Reads and iss_ok are combinational; data, busy bits and busy_cnt update on the rising edge.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ok,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_ok;
  logic              iss_set;
  logic              cnt_inc;
  logic              cnt_dec;

  always_comb begin
    wr_ok   = we && !(ZERO_REG != 0 && wa == '0);
    iss_ok  = !busy[iss_addr] || (wr_ok && wa == iss_addr);
    iss_set = iss_en && iss_ok && !(ZERO_REG != 0 && iss_addr == '0);
    cnt_inc = iss_set && !busy[iss_addr];
    // a clear that is overridden by a set on the same entry is not a 1->0 transition
    cnt_dec = wr_ok && busy[wa] && !(iss_set && iss_addr == wa);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_ok) begin
        mem[wa]  <= wd;
        busy[wa] <= 1'b0;
      end
      if (iss_set) busy[iss_addr] <= 1'b1;
      case ({cnt_inc, cnt_dec})
        2'b10:   busy_cnt <= busy_cnt + CNT_ONE;
        2'b01:   busy_cnt <= busy_cnt - CNT_ONE;
        default: busy_cnt <= busy_cnt;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic              zero;
    assign ra   = rd_addr[i*ADDR_W +: ADDR_W];
    assign hit  = BYPASS != 0 && wr_ok && wa == ra;
    assign zero = ZERO_REG != 0 && ra == '0;
    assign rd_data[i*DATA_W +: DATA_W] = zero ? '0 : (hit ? wd : mem[ra]);
    assign rd_busy[i] = !zero && !hit && busy[ra];
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a bypassing and a non-bypassing instance share stimulus and
// are checked against an array-based model, a fixed vector table and randomized traffic.
module tb_regfile_scoreboard;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, we, iss_en;
  logic [AW-1:0] wa, iss_addr;
  logic [DW-1:0] wd;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]    rd_busy_b, rd_busy_n;
  logic             iss_ok_b, iss_ok_n;
  logic [AW:0]      cnt_b, cnt_n;

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1)) u_byp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_ok(iss_ok_b), .busy_cnt(cnt_b));

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0), .ZERO_REG(1)) u_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_ok(iss_ok_n), .busy_cnt(cnt_n));

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_mem [32];
  bit            m_busy [32];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_legal();
    return we && wa != 0;
  endfunction

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && m_legal() && wa == a) return wd;
    return m_mem[a];
  endfunction

  function automatic bit m_bz(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && m_legal() && wa == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic bit m_ok();
    return !m_busy[iss_addr] || (m_legal() && wa == iss_addr);
  endfunction

  function automatic int m_cnt();
    int n = 0;
    for (int k = 0; k < 32; k++) n += int'(m_busy[k]);
    return n;
  endfunction

  task automatic m_step();
    bit ok;
    if (rst) begin
      for (int k = 0; k < 32; k++) begin
        m_mem[k]  = '0;
        m_busy[k] = 1'b0;
      end
    end else begin
      ok = m_ok();
      if (m_legal()) begin
        m_mem[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (iss_en && ok && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  endtask

  task automatic check_model();
    for (int p = 0; p < NR; p++) begin
      logic [AW-1:0] a;
      a = rd_addr[p*AW +: AW];
      chk("byp_rd_data", 64'(rd_data_b[p*DW +: DW]), 64'(m_rd(a, 1'b1)));
      chk("byp_rd_busy", 64'(rd_busy_b[p]), 64'(m_bz(a, 1'b1)));
      chk("nb_rd_data", 64'(rd_data_n[p*DW +: DW]), 64'(m_rd(a, 1'b0)));
      chk("nb_rd_busy", 64'(rd_busy_n[p]), 64'(m_bz(a, 1'b0)));
    end
    chk("byp_iss_ok", 64'(iss_ok_b), 64'(m_ok()));
    chk("nb_iss_ok", 64'(iss_ok_n), 64'(m_ok()));
    chk("byp_busy_cnt", 64'(cnt_b), 64'(m_cnt()));
    chk("nb_busy_cnt", 64'(cnt_n), 64'(m_cnt()));
  endtask

  // inputs are already set at the falling edge; check combinational outputs, then clock
  task automatic apply();
    #1;
    check_model();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; we = 0; wa = '0; wd = '0; iss_en = 0; iss_addr = '0;
  endtask

  typedef struct {
    logic rst, we; logic [AW-1:0] wa; logic [DW-1:0] wd;
    logic iss_en; logic [AW-1:0] ia, ra0, ra1;
    logic [DW-1:0] e_rd0, e_rd1; logic e_b0, e_b1, e_ok; logic [AW:0] e_cnt;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, 31));
  endfunction

  initial begin
    //            rst we wa wd            ie ia  ra0 ra1  rd0           rd1           b0 b1 ok cnt
    tbl[0]  = '{0, 0, 0,  'h0,          0, 0,  0,  31, 'h0,         'h0,         0, 0, 1, 0};
    tbl[1]  = '{0, 1, 5,  'hDEADBEEF,   0, 0,  5,  5,  'hDEADBEEF,  'hDEADBEEF,  0, 0, 1, 0};
    tbl[2]  = '{0, 1, 0,  'h1234,       1, 0,  0,  5,  'h0,         'hDEADBEEF,  0, 0, 1, 0};
    tbl[3]  = '{0, 0, 0,  'h0,          1, 7,  7,  0,  'h0,         'h0,         0, 0, 1, 0};
    tbl[4]  = '{0, 0, 0,  'h0,          1, 7,  7,  0,  'h0,         'h0,         1, 0, 0, 1};
    tbl[5]  = '{0, 1, 7,  'h77,         1, 7,  7,  7,  'h77,        'h77,        0, 0, 1, 1};
    tbl[6]  = '{0, 0, 0,  'h0,          0, 7,  7,  0,  'h77,        'h0,         1, 0, 0, 1};
    tbl[7]  = '{0, 1, 7,  'h700,        0, 7,  7,  0,  'h700,       'h0,         0, 0, 1, 1};
    tbl[8]  = '{0, 0, 0,  'h0,          1, 3,  7,  3,  'h700,       'h0,         0, 0, 1, 0};
    tbl[9]  = '{0, 0, 0,  'h0,          1, 4,  3,  4,  'h0,         'h0,         1, 0, 1, 1};
    tbl[10] = '{0, 1, 3,  'h33,         1, 9,  3,  9,  'h33,        'h0,         0, 0, 1, 2};
    tbl[11] = '{0, 0, 0,  'h0,          0, 3,  4,  9,  'h0,         'h0,         1, 1, 1, 2};
    tbl[12] = '{0, 0, 0,  'h0,          1, 10, 3,  0,  'h33,        'h0,         0, 0, 1, 2};
    tbl[13] = '{0, 0, 0,  'h0,          1, 11, 10, 11, 'h0,         'h0,         1, 0, 1, 3};
    tbl[14] = '{1, 1, 10, 'hAAAA,       1, 4,  10, 4,  'hAAAA,      'h0,         0, 1, 0, 4};
    tbl[15] = '{0, 0, 0,  'h0,          0, 4,  10, 9,  'h0,         'h0,         0, 0, 1, 0};
    tbl[16] = '{0, 0, 0,  'h0,          0, 11, 5,  3,  'h0,         'h0,         0, 0, 1, 0};

    idle();
    rd_addr = '0;
    rst = 1;
    @(posedge clk);
    m_step();
    @(negedge clk);
    idle();

    for (int a = 0; a < 32; a++) begin
      rd_addr = {AW'(31 - a), AW'(a)};
      #1;
      chk("reset_rd_data", 64'(rd_data_b), 64'h0);
      chk("reset_rd_busy", 64'(rd_busy_b), 64'h0);
      chk("reset_busy_cnt", 64'(cnt_b), 64'h0);
      chk("reset_iss_ok", 64'(iss_ok_b), 64'h1);
      apply();
    end

    for (int r = 0; r < 17; r++) begin
      rst = tbl[r].rst; we = tbl[r].we; wa = tbl[r].wa; wd = tbl[r].wd;
      iss_en = tbl[r].iss_en; iss_addr = tbl[r].ia;
      rd_addr = {tbl[r].ra1, tbl[r].ra0};
      #1;
      chk($sformatf("vec%0d_rd0", r), 64'(rd_data_b[DW-1:0]), 64'(tbl[r].e_rd0));
      chk($sformatf("vec%0d_rd1", r), 64'(rd_data_b[2*DW-1:DW]), 64'(tbl[r].e_rd1));
      chk($sformatf("vec%0d_busy0", r), 64'(rd_busy_b[0]), 64'(tbl[r].e_b0));
      chk($sformatf("vec%0d_busy1", r), 64'(rd_busy_b[1]), 64'(tbl[r].e_b1));
      chk($sformatf("vec%0d_iss_ok", r), 64'(iss_ok_b), 64'(tbl[r].e_ok));
      chk($sformatf("vec%0d_cnt", r), 64'(cnt_b), 64'(tbl[r].e_cnt));
      apply();
    end

    // non-bypassing instance sees the old value during the write cycle, new value after
    idle();
    we = 1; wa = 5; wd = 32'hDEADBEEF; rd_addr = {AW'(0), AW'(5)};
    #1;
    chk("nobyp_same_cycle", 64'(rd_data_n[DW-1:0]), 64'h0);
    chk("byp_same_cycle", 64'(rd_data_b[DW-1:0]), 64'hDEADBEEF);
    apply();
    idle();
    #1;
    chk("nobyp_next_cycle", 64'(rd_data_n[DW-1:0]), 64'hDEADBEEF);
    apply();

    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      we       = 1'($urandom_range(0, 1));
      wa       = pick_addr();
      wd       = $urandom;
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = pick_addr();
      rd_addr  = {pick_addr(), pick_addr()};
      apply();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
